// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC + credit-gated memory requests feeding a {pc, instr} FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  output logic        cs_n,
  input  logic [31:0] instrCode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               CNT_W      = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   C_DEPTH    = (CNT_W + 1)'(DEPTH);

  logic [31:0]      r_pc;
  logic             r_inflight;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic             r_misalign;
  logic [31:0]      r_q_pc    [DEPTH];
  logic [31:0]      r_q_instr [DEPTH];

  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_occupancy;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop       = if_valid & if_ready;
  assign w_push      = r_inflight & ~redirect_valid;
  // Credit counts the in-flight word as already occupying a slot.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight}
                     - {{CNT_W{1'b0}}, w_pop};
  assign w_issue     = rst & ~redirect_valid & (w_occupancy < C_DEPTH);

  assign cs_n     = ~w_issue;
  assign iaddr    = r_pc;
  assign if_valid = (r_count != '0);
  assign if_pc    = if_valid ? r_q_pc[r_rd_ptr]    : 32'd0;
  assign if_instr = if_valid ? r_q_instr[r_rd_ptr] : 32'd0;
  assign misalign = r_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // r_pc has already advanced past the word being returned.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_pc - 32'd4;
      r_q_instr[r_wr_ptr] <= instrCode;
    end
  end

endmodule
`default_nettype wire
